// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter, hardware return-address stack and halt
// state of the MUSA core. The PC advances only on the write_pc commit strobe.
// Optional feature macro: PC_STACK_RESUME_EN adds a resume input that leaves
// HALT and continues at pc_out+1.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_RUN  | normal operation, PC/stack update on write_pc
//   ST_HALT | core halted, pc_out frozen, write_pc/push/pop ignored

module pc_stack_unit #(
    parameter int                 ADDR_W      = 16,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_pc,
    input  logic [2:0]        branch,
    input  logic              brfl_control,
    input  logic              flag_cond,
    input  logic              push,
    input  logic              pop,
    input  logic              add_pc,
    input  logic [ADDR_W-1:0] target_addr,
`ifdef PC_STACK_RESUME_EN
    input  logic              resume,
`endif
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_ovf,
    output logic              stack_udf
);

    localparam int            IDX_W   = $clog2(STACK_DEPTH);
    localparam int            SP_W    = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [2:0] BR_JUMP = 3'b010;
    localparam logic [2:0] BR_HALT = 3'b101;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic [SP_W-1:0]   sp, sp_nxt;
    logic              ovf, ovf_nxt, udf, udf_nxt;
    logic              stk_we;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    assign pc_inc      = pc + ADDR_W'(1);
    assign push_idx    = IDX_W'(sp);
    assign pop_idx     = IDX_W'(sp - SP_W'(1));

    assign pc_out      = pc;
    assign halted      = (state == ST_HALT);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign stack_ovf   = ovf;
    assign stack_udf   = udf;

    // Next-state decode: halt beats push, push beats pop, pop beats branches.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        ovf_nxt   = ovf;
        udf_nxt   = udf;
        stk_we    = 1'b0;
        case (state)
            ST_RUN: begin
                if (write_pc) begin
                    if (branch == BR_HALT) begin
                        state_nxt = ST_HALT;
                    end else if (push) begin
                        if (!stack_full) begin
                            stk_we = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                            pc_nxt = target_addr;
                        end else begin
                            ovf_nxt = 1'b1;
                            pc_nxt  = pc_inc;
                        end
                    end else if (pop) begin
                        if (!stack_empty) begin
                            sp_nxt = sp - SP_W'(1);
                            pc_nxt = stack_mem[pop_idx] + ADDR_W'(add_pc);
                        end else begin
                            udf_nxt = 1'b1;
                            pc_nxt  = pc_inc;
                        end
                    end else if (branch == BR_JUMP) begin
                        pc_nxt = (!brfl_control || flag_cond) ? target_addr : pc_inc;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            ST_HALT: begin
`ifdef PC_STACK_RESUME_EN
                if (resume) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = pc_inc;
                end
`endif
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State, PC, stack pointer and sticky flags; reset wins over write_pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            sp    <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            sp    <= sp_nxt;
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
        end
    end

    // Return-address storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && stk_we) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit: table of vectors plus stack fill/drain and
// (when PC_STACK_RESUME_EN is defined) resume sequences, via a scoreboard queue.

module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        rst_n, write_pc, brfl_control, flag_cond, push, pop, add_pc;
    logic [2:0]  branch;
    logic [15:0] target_addr;
    logic [15:0] pc_out;
    logic        halted, stack_empty, stack_full, stack_ovf, stack_udf;
`ifdef PC_STACK_RESUME_EN
    logic        resume;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // flag vector order: {empty, full, halted, ovf, udf}
    localparam logic [4:0] E = 5'b10000, F = 5'b01000, H = 5'b00100,
                           O = 5'b00010, U = 5'b00001, Z = 5'b00000;

    typedef struct {
        string       name;
        logic        rst_n, wp;
        logic [2:0]  br;
        logic        brfl, flg, psh, pp, addp, res;
        logic [15:0] tgt;
        logic [15:0] exp_pc;
        logic [4:0]  exp_fl;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [4:0]  fl;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    pc_stack_unit #(.ADDR_W(16), .STACK_DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .write_pc(write_pc), .branch(branch),
        .brfl_control(brfl_control), .flag_cond(flag_cond), .push(push),
        .pop(pop), .add_pc(add_pc), .target_addr(target_addr),
`ifdef PC_STACK_RESUME_EN
        .resume(resume),
`endif
        .pc_out(pc_out), .halted(halted), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_ovf(stack_ovf), .stack_udf(stack_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string n, logic r, logic wp, logic [2:0] br,
                                logic brfl, logic flg, logic psh, logic pp,
                                logic addp, logic [15:0] tgt,
                                logic [15:0] epc, logic [4:0] efl);
        vec_t v;
        v.name = n; v.rst_n = r; v.wp = wp; v.br = br; v.brfl = brfl;
        v.flg = flg; v.psh = psh; v.pp = pp; v.addp = addp; v.res = 1'b0;
        v.tgt = tgt; v.exp_pc = epc; v.exp_fl = efl;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        logic [4:0] got;
        if (exp_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL scoreboard: queue empty when output sampled");
            return;
        end
        e = exp_q.pop_front();
        got = {stack_empty, stack_full, halted, stack_ovf, stack_udf};
        n_checks++;
        if (pc_out !== e.pc) begin
            n_fails++;
            $display("FAIL %s pc_out: got %h expected %h", e.name, pc_out, e.pc);
        end
        n_checks++;
        if (got !== e.fl) begin
            n_fails++;
            $display("FAIL %s flags{empty,full,halted,ovf,udf}: got %b expected %b",
                     e.name, got, e.fl);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; write_pc = v.wp; branch = v.br; brfl_control = v.brfl;
        flag_cond = v.flg; push = v.psh; pop = v.pp; add_pc = v.addp;
        target_addr = v.tgt;
`ifdef PC_STACK_RESUME_EN
        resume = v.res;
`endif
        exp_q.push_back('{v.name, v.exp_pc, v.exp_fl});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        vec_t v;
        logic [15:0] ev;
        rst_n = 1'b0; write_pc = 1'b0; branch = 3'b000; brfl_control = 1'b0;
        flag_cond = 1'b0; push = 1'b0; pop = 1'b0; add_pc = 1'b0;
        target_addr = 16'h0000;
`ifdef PC_STACK_RESUME_EN
        resume = 1'b0;
`endif

        //            name        rst wp br      bf fl ps pp ad tgt       exp_pc    flags
        tbl.push_back(mk("reset",     0, 0, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, E));
        tbl.push_back(mk("seq1",      1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, E));
        tbl.push_back(mk("seq2",      1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, E));
        tbl.push_back(mk("seq3",      1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, E));
        tbl.push_back(mk("glitch",    1, 0, 3'b010, 0, 1, 1, 1, 1, 16'h0055, 16'h0003, E));
        tbl.push_back(mk("jmp10",     1, 1, 3'b010, 0, 0, 0, 0, 0, 16'h0010, 16'h0010, E));
        tbl.push_back(mk("call40",    1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0040, 16'h0040, Z));
        tbl.push_back(mk("ret",       1, 1, 3'b000, 0, 0, 0, 1, 0, 16'h0000, 16'h0011, E));
        tbl.push_back(mk("jmp5",      1, 1, 3'b010, 0, 0, 0, 0, 0, 16'h0005, 16'h0005, E));
        tbl.push_back(mk("bcc_nt",    1, 1, 3'b010, 1, 0, 0, 0, 0, 16'h0020, 16'h0006, E));
        tbl.push_back(mk("jmp5b",     1, 1, 3'b010, 0, 0, 0, 0, 0, 16'h0005, 16'h0005, E));
        tbl.push_back(mk("bcc_t",     1, 1, 3'b010, 1, 1, 0, 0, 0, 16'h0020, 16'h0020, E));
        tbl.push_back(mk("push_pop",  1, 1, 3'b000, 0, 0, 1, 1, 0, 16'h0080, 16'h0080, Z));
        tbl.push_back(mk("ret_add",   1, 1, 3'b000, 0, 0, 0, 1, 1, 16'h0000, 16'h0022, E));
        tbl.push_back(mk("jmpffff",   1, 1, 3'b010, 0, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, E));
        tbl.push_back(mk("wrap",      1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, E));
        tbl.push_back(mk("br011",     1, 1, 3'b011, 0, 0, 0, 0, 0, 16'h0077, 16'h0001, E));
        tbl.push_back(mk("br110",     1, 1, 3'b110, 1, 1, 0, 0, 0, 16'h0077, 16'h0002, E));
        tbl.push_back(mk("jmp30",     1, 1, 3'b010, 0, 0, 0, 0, 0, 16'h0030, 16'h0030, E));
        tbl.push_back(mk("halt",      1, 1, 3'b101, 0, 0, 1, 0, 0, 16'h0099, 16'h0030, E|H));
        tbl.push_back(mk("halt_jmp",  1, 1, 3'b010, 0, 0, 0, 0, 0, 16'h0099, 16'h0030, E|H));
        tbl.push_back(mk("halt_push", 1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0099, 16'h0030, E|H));
        tbl.push_back(mk("halt_pop",  1, 1, 3'b000, 0, 0, 0, 1, 0, 16'h0000, 16'h0030, E|H));
        tbl.push_back(mk("reset2",    0, 0, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, E));
        tbl.push_back(mk("seq_a",     1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, E));
        tbl.push_back(mk("rst_wp",    0, 1, 3'b010, 0, 0, 1, 0, 0, 16'h0044, 16'h0000, E));

        foreach (tbl[i]) step(tbl[i]);

        // Fill the stack from pc=0: return addresses 0x0001, 0x0101..0x0107.
        for (int i = 0; i < 8; i++) begin
            step(mk("call_fill", 1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0100 + 16'(i),
                    16'h0100 + 16'(i), (i == 7) ? F : Z));
        end
        step(mk("call_ovf", 1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0200, 16'h0108, F|O));
        for (int i = 0; i < 8; i++) begin
            ev = (i == 7) ? 16'h0001 : 16'h0100 + 16'(7 - i);
            step(mk("ret_drain", 1, 1, 3'b000, 0, 0, 0, 1, 0, 16'h0000, ev,
                    (i == 7) ? (E|O) : O));
        end
        step(mk("ret_udf",   1, 1, 3'b000, 0, 0, 0, 1, 0, 16'h0000, 16'h0002, E|O|U));
        step(mk("call_stky", 1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0300, 16'h0300, O|U));
        step(mk("hold",      1, 0, 3'b101, 0, 0, 0, 0, 0, 16'h0000, 16'h0300, O|U));
        step(mk("reset3",    0, 0, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, E));

`ifdef PC_STACK_RESUME_EN
        v = mk("res_run", 1, 0, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, E);
        v.res = 1'b1;
        step(v);
        step(mk("call_r",   1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0030, 16'h0030, Z));
        step(mk("halt_r",   1, 1, 3'b101, 0, 0, 0, 0, 0, 16'h0000, 16'h0030, H));
        step(mk("halt_r2",  1, 0, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0030, H));
        v = mk("resume",    1, 1, 3'b000, 0, 0, 1, 0, 0, 16'h0077, 16'h0031, Z);
        v.res = 1'b1;
        step(v);
        step(mk("ret_r",    1, 1, 3'b000, 0, 0, 0, 1, 0, 16'h0000, 16'h0001, E));
`else
        v = mk("post_seq", 1, 1, 3'b000, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, E);
        step(v);
`endif

        if (exp_q.size() != 0) begin
            n_checks++; n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and call/return-stack unit directly downstream of the multicycle control unit.
- Consumes the per-instruction commit strobe write_pc, the branch code, and the brfl_control, push, pop and add_pc controls.
- Produces the PC that addresses instruction memory for the next fetch.
- Owns the hardware return-address stack and the halt state of the MUSA core.

Parameters:
ADDR_W, 16, width of PC, jump target and stack entries
STACK_DEPTH, 8, number of return-address entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
write_pc  input  1  one-cycle commit strobe from control unit, PC updates only when high
branch  input  3  branch code: 000 sequential, 010 jump/branch, 101 halt, other values treated as 000
brfl_control  input  1  qualifies branch=010 as conditional (flag branch)
flag_cond  input  1  branch condition from ALU flag register, sampled with write_pc
push  input  1  call: save return address, jump to target
pop  input  1  ret: restore PC from stack
add_pc  input  1  with pop: return to popped value + 1
target_addr  input  ADDR_W  jump/call target (immediate or register value)
pc_out  output  ADDR_W  current PC
halted  output  1  core halted
stack_empty  output  1  stack pointer is 0
stack_full  output  1  stack pointer is STACK_DEPTH
stack_ovf  output  1  sticky: push attempted while full
stack_udf  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_n=0 at rising edge): pc_out=RESET_PC, sp=0, halted=0, stack_ovf=0, stack_udf=0, state=RUN.
- Stack contents are not cleared on reset.
- FSM states:
  - RUN: PC updates on write_pc.
  - HALT: pc_out frozen; write_pc, push and pop are ignored; exits only via reset, or via resume when the optional feature is enabled.
- Latency: pc_out takes its new value on the rising edge that samples write_pc=1, so it is visible one cycle after the strobe. With write_pc=0, all state is held.
- Decision priority when write_pc=1 in RUN, highest first:
  1. branch=101: halted=1, state=HALT, pc_out unchanged.
  2. push: if sp<STACK_DEPTH, stack[sp]=pc_out+1, sp=sp+1, pc_out=target_addr. If full, set stack_ovf, no write, pc_out=pc_out+1.
  3. pop: if sp>0, sp=sp-1, pc_out=stack[sp-1]+add_pc. If empty, set stack_udf, pc_out=pc_out+1.
  4. branch=010 with brfl_control=1: pc_out=target_addr if flag_cond=1, else pc_out+1.
  5. branch=010 with brfl_control=0: pc_out=target_addr.
  6. Otherwise: pc_out=pc_out+1.
- push and pop both high: push wins, pop ignored, no flag raised.
- Arithmetic: all PC math is modulo 2^ADDR_W. 0xFFFF+1 wraps to 0x0000 without any flag.
- sp is clog2(STACK_DEPTH)+1 bits wide. stack_empty=(sp==0), stack_full=(sp==STACK_DEPTH), both combinational from sp.
- stack_ovf and stack_udf are sticky until reset.
- Reset asserted mid-instruction overrides any simultaneous write_pc.
- Control inputs are level-sampled only in the write_pc cycle. Glitches while write_pc=0 have no effect.

Optional Feature:
- Macro: PC_STACK_RESUME_EN.
- When defined:
  - Adds input resume (1 bit).
  - In HALT, resume=1 at a rising edge returns to RUN, clears halted, and sets pc_out=pc_out+1; the stack is untouched.
  - In RUN, resume is ignored.
- When undefined: no resume port, and HALT is left only by reset.

Test Plan:
- Reset then 3 write_pc pulses with branch=000 -> pc_out 0x0000, 0x0001, 0x0002, 0x0003; stack_empty=1, halted=0.
- At pc=0x0010, write_pc with push=1, target=0x0040; then write_pc with pop=1, add_pc=0 -> pc_out 0x0040 then 0x0011, sp returns to 0, stack_empty=1.
- At pc=0x0005, branch=010, brfl_control=1, target=0x0020: flag_cond=0 -> pc_out=0x0006; repeat with flag_cond=1 -> pc_out=0x0020.
- 8 calls (targets 0x0100..0x0107) -> stack_full=1; 9th call -> stack_ovf=1, pc_out=0x0108, sp stays 8; then 8 pops -> last restores 0x0001 when starting from pc=0x0000; 9th pop -> stack_udf=1.
- pc=0x0030, branch=101 with write_pc -> halted=1; following write_pc pulses with branch=010, target=0x0099 -> pc_out stays 0x0030; rst_n=0 -> pc_out=0x0000, halted=0, both sticky flags 0.
- PC_STACK_RESUME_EN defined: halt at 0x0030, pulse resume -> halted=0, pc_out=0x0031. Separately, pc=0xFFFF with sequential write_pc -> pc_out=0x0000.
